datamem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port data memory between N_REQ requesters (SIMD lanes / cores).
- Accepts one request at a time, issues it to the memory for exactly one cycle, then returns a registered response to the winner.
- Sits between the lane load/store units and the data memory.
- Drives the memory's write-enable, address and write-data inputs; samples its combinational read-data output.

---
 rtl/datamem_arbiter_if.sv | 27 ++
 rtl/datamem_arbiter.sv | 94 +++++++++
 tb/tb_datamem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/datamem_arbiter_if.sv
// datamem_arbiter_if: requester and data-memory bundle shared by the arbiter and its environment
interface datamem_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [DATA_W-1:0]       mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_write, mem_addr, mem_wdata
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/datamem_arbiter.sv
// datamem_arbiter: round-robin arbiter sharing one single-port data memory among N_REQ requesters
module datamem_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input logic              clk,
    input logic              reset_n,
    datamem_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d, id_q, id_d, win;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              write_q, write_d, found, grant;
    logic [N_REQ-1:0]  rsp_q, rsp_d;
    int                j;

    // Scan from the highest offset down so the requester nearest ptr wins last
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (bus.req_valid[j]) begin
                win   = PW'(j);
                found = 1'b1;
            end
        end
    end

    assign grant = reset_n && state_q == IDLE && found;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        rsp_d   = '0;
        if (grant) begin
            state_d = ISSUE;
            ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            id_d    = win;
            write_d = bus.req_write[win];
            addr_d  = bus.req_addr[win*ADDR_W +: ADDR_W];
            wdata_d = bus.req_wdata[win*DATA_W +: DATA_W];
        end
        if (state_q == ISSUE) begin
            state_d = IDLE;
            rsp_d   = ONE << id_q;
            if (!write_q) rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
        end
    end

    // Write enable comes only from registers, so an async reset drops it at once
    assign bus.mem_write = state_q == ISSUE && write_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.req_ready = grant ? ONE << win : '0;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_datamem_arbiter.sv
// tb_datamem_arbiter: directed scenarios against a behavioural single-port memory
module tb_datamem_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    datamem_arbiter_if #(.N_REQ(4), .ADDR_W(16), .DATA_W(16)) bus ();
    datamem_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    logic [15:0] mem [0:255];
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic w,
                            input logic [15:0] a, input logic [15:0] d);
        bus.req_valid[i]          = v;
        bus.req_write[i]          = w;
        bus.req_addr[i*16 +: 16]  = a;
        bus.req_wdata[i*16 +: 16] = d;
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        step;
        step;
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 16'(i), 16'h0);
        #2;
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.rsp_rdata); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0000", bus.mem_wdata); end
        step;
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready_edge: got %b want 0000", bus.req_ready); end
        for (int i = 0; i < 4; i++) set_lane(i, 1'b0, 1'b0, 16'h0, 16'h0);
        step;
        reset_n = 1'b1;
    endtask

    task automatic test_read;
        step;
        set_lane(0, 1'b1, 1'b0, 16'd5, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL read_grant: got %b want 0001", bus.req_ready); end
        step;
        set_lane(0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++; if (bus.mem_addr !== 16'd5) begin errors++; $display("FAIL read_mem_addr: got %h want 0005", bus.mem_addr); end
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL read_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL read_early_rsp: got %b want 0000", bus.rsp_valid); end
        step;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL read_rsp_valid: got %b want 0001", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h1234) begin errors++; $display("FAIL read_rdata: got %h want 1234", bus.rsp_rdata); end
        step;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL read_rsp_pulse: got %b want 0000", bus.rsp_valid); end
    endtask

    task automatic test_write_read;
        step;
        set_lane(2, 1'b1, 1'b1, 16'd9, 16'hBEEF);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wr_grant: got %b want 0100", bus.req_ready); end
        step;
        set_lane(2, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL wr_mem_write: got %b want 1", bus.mem_write); end
        checks++; if (bus.mem_addr !== 16'd9) begin errors++; $display("FAIL wr_mem_addr: got %h want 0009", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_mem_wdata: got %h want beef", bus.mem_wdata); end
        step;
        set_lane(1, 1'b1, 1'b0, 16'd9, 16'h0);
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL wr_one_cycle: got %b want 0", bus.mem_write); end
        checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL wr_ack: got %b want 0100", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rd_grant: got %b want 0010", bus.req_ready); end
        step;
        set_lane(1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rd_mem_write: got %b want 0", bus.mem_write); end
        checks++; if (bus.mem_addr !== 16'd9) begin errors++; $display("FAIL rd_mem_addr: got %h want 0009", bus.mem_addr); end
        step;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_rsp_valid: got %b want 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_after_wr: got %h want beef", bus.rsp_rdata); end
    endtask

    task automatic test_all_lanes;
        logic [3:0] e;
        apply_reset;
        step;
        for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 16'(10 + i), 16'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            e = 4'b0001 << k;
            checks++; if (bus.req_ready !== e) begin errors++; $display("FAIL all_grant%0d: got %b want %b", k, bus.req_ready, e); end
            if (k > 0) begin
                e = 4'b0001 << (k - 1);
                checks++; if (bus.rsp_valid !== e) begin errors++; $display("FAIL all_rsp%0d: got %b want %b", k - 1, bus.rsp_valid, e); end
                checks++; if (bus.rsp_rdata !== 16'(16'hA000 + k - 1)) begin errors++; $display("FAIL all_rdata%0d: got %h want %h", k - 1, bus.rsp_rdata, 16'(16'hA000 + k - 1)); end
            end
            step;
            set_lane(k, 1'b0, 1'b0, 16'h0, 16'h0);
            #1;
            checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL all_issue_ready%0d: got %b want 0000", k, bus.req_ready); end
            checks++; if (bus.mem_addr !== 16'(10 + k)) begin errors++; $display("FAIL all_addr%0d: got %h want %h", k, bus.mem_addr, 16'(10 + k)); end
            step;
        end
        #1;
        checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL all_rsp3: got %b want 1000", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'hA003) begin errors++; $display("FAIL all_rdata3: got %h want a003", bus.rsp_rdata); end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_g [4];
        exp_g = '{4'b0001, 4'b1000, 4'b0001, 4'b0001};
        step;
        set_lane(0, 1'b1, 1'b0, 16'd20, 16'h0);
        set_lane(3, 1'b1, 1'b0, 16'd30, 16'h0);
        for (int g = 0; g < 4; g++) begin
            #1;
            checks++; if (bus.req_ready !== exp_g[g]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", g, bus.req_ready, exp_g[g]); end
            step;
            if (exp_g[g] == 4'b1000) set_lane(3, 1'b0, 1'b0, 16'h0, 16'h0);
            set_lane(0, g != 3, 1'b0, 16'(21 + g), 16'h0);
            #1;
            checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL fair_issue%0d: got %b want 0000", g, bus.req_ready); end
            step;
        end
        #1;
        checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL fair_last_rsp: got %b want 0001", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid_issue;
        step;
        set_lane(2, 1'b1, 1'b1, 16'd7, 16'hAAAA);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rst_grant: got %b want 0100", bus.req_ready); end
        step;
        set_lane(2, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++; if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rst_mem_write_pre: got %b want 1", bus.mem_write); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write_async: got %b want 0", bus.mem_write); end
        step;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_no_rsp: got %b want 0000", bus.rsp_valid); end
        checks++; if (mem[7] !== 16'h0007) begin errors++; $display("FAIL rst_no_commit: got %h want 0007", mem[7]); end
        reset_n = 1'b1;
        step;
        set_lane(0, 1'b1, 1'b0, 16'd5, 16'h0);
        set_lane(1, 1'b1, 1'b0, 16'd5, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr_idle: got %b want 0001", bus.req_ready); end
        step;
        set_lane(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_lane(1, 1'b0, 1'b0, 16'h0, 16'h0);
        step;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_after_rsp: got %b want 0001", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 16'h1234) begin errors++; $display("FAIL rst_after_rdata: got %h want 1234", bus.rsp_rdata); end
    endtask

    task automatic test_drop;
        step;
        set_lane(0, 1'b1, 1'b0, 16'd5, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL drop_grant: got %b want 0001", bus.req_ready); end
        step;
        set_lane(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_lane(1, 1'b1, 1'b0, 16'd9, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL drop_issue_ready: got %b want 0000", bus.req_ready); end
        step;
        set_lane(1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL drop_rsp0: got %b want 0001", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL drop_ready: got %b want 0000", bus.req_ready); end
        for (int c = 0; c < 3; c++) begin
            step;
            #1;
            checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL drop_rsp%0d: got %b want 0000", c, bus.rsp_valid); end
            checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL drop_mem_write%0d: got %b want 0", c, bus.mem_write); end
            checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL drop_idle_ready%0d: got %b want 0000", c, bus.req_ready); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
        mem[5] = 16'h1234;
        for (int i = 0; i < 4; i++) mem[10 + i] = 16'(16'hA000 + i);
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset;
        test_read;
        test_write_read;
        test_all_lanes;
        test_fairness;
        test_reset_mid_issue;
        test_drop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
